// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline stall controller: FSM states and the
// per-stage control vector with its NORMAL/FREEZE presets.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } ctrl_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                    id_ex_write: 1'b1, id_ex_bubble: 1'b0,
                                    ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_write: 1'b0, id_ex_bubble: 1'b0,
                                    ex_mem_write: 1'b0, mem_wb_bubble: 1'b1};

  // Unfrozen decode: branch squashes the dependent op, so it wins over load-use.
  function automatic ctrl_t run_ctrl(input logic branch_taken, input logic hazard_stall);
    ctrl_t c;
    c = CTRL_NORMAL;
    if (branch_taken) begin
      c.if_id_flush  = 1'b1;
      c.id_ex_bubble = 1'b1;
    end else if (hazard_stall) begin
      c.pc_write     = 1'b0;
      c.if_id_write  = 1'b0;
      c.id_ex_bubble = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central 5-stage pipeline control: Mealy stall/flush decode, memory-wait FSM
// with timeout trap, and stall/flush performance counters.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       ctrl_state
);

  localparam int WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  ctrl_state_e   state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  ctrl_t         ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      wait_q          <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_d == ERROR) mem_timeout_err <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ctrl    = CTRL_NORMAL;
    case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          ctrl    = CTRL_FREEZE;
          state_d = MEM_WAIT;
          wait_d  = '0;
        end else begin
          ctrl = run_ctrl(branch_taken, hazard_stall);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          ctrl    = run_ctrl(branch_taken, hazard_stall);
          state_d = RUN;
        end else begin
          ctrl   = CTRL_FREEZE;
          wait_d = wait_q + 1'b1;
          if (wait_q == WAIT_LAST) state_d = ERROR;
        end
      end
      ERROR: ctrl = CTRL_FREEZE;
      default: begin
        ctrl    = CTRL_FREEZE;
        state_d = RUN;
      end
    endcase
    // Hold everything and inject a bubble while reset is asserted.
    if (!rst_n) begin
      ctrl              = CTRL_FREEZE;
      ctrl.id_ex_bubble = 1'b1;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_ex_write   = ctrl.id_ex_write;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_mem_write  = ctrl.ex_mem_write;
  assign mem_wb_bubble = ctrl.mem_wb_bubble;
  assign ctrl_state    = state_q;

  // FREEZE and load-use stalls are exactly the cycles with the PC held.
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~ctrl.pc_write),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.if_id_flush),
    .count (flush_count)
  );

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central pipeline control for the 5-stage core. Consumes the load-use `stall` request from the hazard detection unit, the EX-stage branch-taken signal and the data-memory request/ready handshake. Drives the per-stage write enables, flush and bubble controls. Includes a multi-cycle memory-wait FSM with a timeout trap and saturating performance counters.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum number of MEM_WAIT cycles with `dmem_ready` low before trapping; must be ≥ 1.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `hazard_stall` in 1: load-use stall request from the hazard detection unit.
- `branch_taken` in 1: taken branch or jump resolved in EX.
- `dmem_req` in 1: MEM stage is issuing a data-memory access.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_write` out 1: PC register enable.
- `if_id_write` out 1: IF/ID enable.
- `if_id_flush` out 1: clear IF/ID to NOP.
- `id_ex_write` out 1: ID/EX enable.
- `id_ex_bubble` out 1: load NOP into ID/EX.
- `ex_mem_write` out 1: EX/MEM enable.
- `mem_wb_bubble` out 1: load NOP into MEM/WB.
- `mem_timeout_err` out 1: sticky trap flag.
- `stall_count` out CNT_W: saturating count of stall cycles.
- `flush_count` out CNT_W: saturating count of branch flushes.
- `ctrl_state` out 2: current FSM state, for debug.

## Operation
FSM states: RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10. Encoding 2'b11 is illegal and recovers to RUN.

Control outputs are combinational from the state and the inputs (Mealy), because stalls must take effect in the same cycle they are requested.

Output sets:
- NORMAL: all `*_write`=1, `if_id_flush`=0, `id_ex_bubble`=0, `mem_wb_bubble`=0.
- FREEZE: `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write` all 0; `mem_wb_bubble`=1; `if_id_flush`=0; `id_ex_bubble`=0.

RUN evaluates in priority order:
1. `dmem_req` && !`dmem_ready`: FREEZE; next state MEM_WAIT; `wait_cnt` cleared to 0.
2. `branch_taken`: NORMAL, plus `if_id_flush`=1 and `id_ex_bubble`=1. Branch outranks a simultaneous `hazard_stall`, because the dependent instruction is squashed anyway.
3. `hazard_stall`: NORMAL, plus `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1.
4. Otherwise: NORMAL.

MEM_WAIT:
- `dmem_ready`=1: outputs as RUN rules 2–4 (`dmem_req` ignored); next state RUN.
- `dmem_ready`=0: FREEZE; `wait_cnt`++.
  - If `wait_cnt`==MEM_TIMEOUT-1, next state is ERROR.
- `branch_taken` and `hazard_stall` are ignored while frozen. Upstream holds them; they are re-evaluated on release.

ERROR: FREEZE permanently; `mem_timeout_err`=1. Only reset exits this state.

Counters:
- `stall_count` increments on every cycle that produces FREEZE or a load-use stall (rule 3).
- `flush_count` increments on every cycle where `if_id_flush`=1.
- Both saturate at all-ones and never wrap.

## Timing
- While `rst_n`=0: state RUN, `wait_cnt`=0, both counters 0, `mem_timeout_err`=0. Control outputs are forced to FREEZE with `id_ex_bubble`=1.
- Reset assertion mid-MEM_WAIT or in ERROR returns the block to RUN asynchronously.
- Control outputs have zero-cycle latency from the inputs.
- State, `wait_cnt`, counters and `mem_timeout_err` update on the next rising edge.
- A memory access ready in its first cycle causes no stall.
- With `dmem_ready` low, the pipeline is frozen for 1 + MEM_TIMEOUT cycles. `mem_timeout_err` then rises at the edge that ends the last of those cycles.

## Structure
- Shared package `pipeline_ctrl_pkg` holds the state encodings RUN, MEM_WAIT and ERROR, and the NORMAL/FREEZE control-vector constants.
- One sub-module, `sat_counter` (parameter WIDTH; ports clk, rst_n, inc, count), instantiated twice.
- FSM, `wait_cnt` and output decode live in the top module.

## Test plan
- Reset, then idle inputs: NORMAL outputs, `ctrl_state`=0, both counters 0, `mem_timeout_err`=0.
- `hazard_stall`=1 for one cycle: same cycle `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1; `stall_count`=1 after the edge.
- `branch_taken`=1 with `hazard_stall`=1: `pc_write`=1, `if_id_flush`=1, `id_ex_bubble`=1; `flush_count`=1, `stall_count`=0.
- `dmem_req`=1 with `dmem_ready` low for 3 cycles, then high: 3 FREEZE cycles, ready cycle NORMAL, state back to RUN, `stall_count`=3. A `branch_taken` held during the wait flushes only in the ready cycle.
- MEM_TIMEOUT=4 and `dmem_ready` never asserted: 5 FREEZE cycles, then `ctrl_state`=2 and `mem_timeout_err`=1, which persist. Pulsing `rst_n` low clears everything.
- CNT_W=4 with `hazard_stall` held for 20 cycles: `stall_count` saturates at 15.
